// File: rtl/dual_run_sequencer.sv
// Back-to-back run sequencer for two lockstep cores: core reset, budgeted fetch, drain, report.
// Optional RUN-state watchdog enabled by defining RUN_TIMEOUT_EN.
module dual_run_sequencer #(
   parameter int unsigned CORE_RST_CYCLES = 8,
   parameter int unsigned DRAIN_CYCLES    = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [31:0] instr_budget_i,
   input  logic [7:0]  num_runs_i,
   input  logic        fetch_1_i,
   input  logic        fetch_2_i,
   input  logic        retire_1_i,
   input  logic        retire_2_i,
   output logic        core_rst_no,
   output logic        enable_1_o,
   output logic        enable_2_o,
   output logic [7:0]  run_idx_o,
   output logic        run_done_o,
   output logic [31:0] retired_1_o,
   output logic [31:0] retired_2_o,
   output logic        timeout_o,
   output logic        busy_o,
   output logic        all_done_o
);

   // state    | meaning
   // IDLE     | after reset, waiting for start
   // CORE_RST | cores held in reset, counters cleared
   // RUN      | fetch gated by per-core budget
   // DRAIN    | fetch stopped, in-flight retires still counted
   // REPORT   | one-cycle run_done pulse, results valid
   // DONE     | all runs complete, waiting for a new start
   typedef enum logic [2:0] {
      S_IDLE, S_CORE_RST, S_RUN, S_DRAIN, S_REPORT, S_DONE
   } state_e;

   localparam logic [31:0] CRST_LOAD  = 32'(CORE_RST_CYCLES - 1);
   localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] budget_q, budget_d;
   logic [7:0]  num_runs_q, num_runs_d;
   logic [7:0]  run_idx_q, run_idx_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] fcnt_1_q, fcnt_1_d, fcnt_2_q, fcnt_2_d;
   logic        en_1_q, en_1_d, en_2_q, en_2_d;
   logic [31:0] ret_1_q, ret_1_d, ret_2_q, ret_2_d;
   logic        core_rst_n_q, core_rst_n_d;
   logic        run_done_q, run_done_d;
   logic        busy_q, busy_d;
   logic        all_done_q, all_done_d;
   logic        enter_crst;
   logic        normal_exit;

`ifdef RUN_TIMEOUT_EN
   localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] tmr_q, tmr_d;
   logic        timeout_q, timeout_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

   assign normal_exit = (!en_1_q && !en_2_q) ||
                        ((ret_1_q >= budget_q) && (ret_2_q >= budget_q));

   always_comb begin
      state_d    = state_q;
      budget_d   = budget_q;
      num_runs_d = num_runs_q;
      run_idx_d  = run_idx_q;
      cnt_d      = cnt_q;
      fcnt_1_d   = fcnt_1_q;
      fcnt_2_d   = fcnt_2_q;
      en_1_d     = en_1_q;
      en_2_d     = en_2_q;
      ret_1_d    = ret_1_q;
      ret_2_d    = ret_2_q;
      enter_crst = 1'b0;
`ifdef RUN_TIMEOUT_EN
      tmr_d      = tmr_q;
      timeout_d  = timeout_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               budget_d   = instr_budget_i;
               num_runs_d = num_runs_i;
               run_idx_d  = 8'd0;
               if (num_runs_i == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_CORE_RST;
                  enter_crst = 1'b1;
               end
            end
         end
         S_CORE_RST: begin
            if (cnt_q == 32'd0) begin
               state_d = S_RUN;
               en_1_d  = (budget_q != 32'd0);
               en_2_d  = (budget_q != 32'd0);
`ifdef RUN_TIMEOUT_EN
               tmr_d   = TMO_LOAD;
`endif
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_RUN: begin
            if (en_1_q && fetch_1_i) begin
               fcnt_1_d = fcnt_1_q + 32'd1;
               if (fcnt_1_q + 32'd1 == budget_q) en_1_d = 1'b0;
            end
            if (en_2_q && fetch_2_i) begin
               fcnt_2_d = fcnt_2_q + 32'd1;
               if (fcnt_2_q + 32'd1 == budget_q) en_2_d = 1'b0;
            end
            if (normal_exit) begin
               state_d = S_DRAIN;
               en_1_d  = 1'b0;
               en_2_d  = 1'b0;
               cnt_d   = DRAIN_LOAD;
`ifdef RUN_TIMEOUT_EN
            end else if (tmr_q == 32'd0) begin
               // Normal exit has priority; the watchdog only fires when it did not.
               state_d   = S_DRAIN;
               en_1_d    = 1'b0;
               en_2_d    = 1'b0;
               cnt_d     = DRAIN_LOAD;
               timeout_d = 1'b1;
            end else begin
               tmr_d = tmr_q - 32'd1;
`endif
            end
         end
         S_DRAIN: begin
            if (cnt_q == 32'd0) state_d = S_REPORT;
            else                cnt_d   = cnt_q - 32'd1;
         end
         S_REPORT: begin
            if (run_idx_q == num_runs_q - 8'd1) begin
               state_d = S_DONE;
            end else begin
               run_idx_d  = run_idx_q + 8'd1;
               state_d    = S_CORE_RST;
               enter_crst = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_RUN || state_q == S_DRAIN) begin
         if (retire_1_i && ret_1_q != 32'hFFFF_FFFF) ret_1_d = ret_1_q + 32'd1;
         if (retire_2_i && ret_2_q != 32'hFFFF_FFFF) ret_2_d = ret_2_q + 32'd1;
      end

      if (enter_crst) begin
         cnt_d    = CRST_LOAD;
         fcnt_1_d = 32'd0;
         fcnt_2_d = 32'd0;
         ret_1_d  = 32'd0;
         ret_2_d  = 32'd0;
`ifdef RUN_TIMEOUT_EN
         timeout_d = 1'b0;
`endif
      end

      core_rst_n_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_REPORT);
      run_done_d   = (state_d == S_REPORT);
      busy_d       = (state_d == S_CORE_RST) || (state_d == S_RUN) ||
                     (state_d == S_DRAIN) || (state_d == S_REPORT);
      all_done_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         budget_q     <= 32'd0;
         num_runs_q   <= 8'd0;
         run_idx_q    <= 8'd0;
         cnt_q        <= 32'd0;
         fcnt_1_q     <= 32'd0;
         fcnt_2_q     <= 32'd0;
         en_1_q       <= 1'b0;
         en_2_q       <= 1'b0;
         ret_1_q      <= 32'd0;
         ret_2_q      <= 32'd0;
         core_rst_n_q <= 1'b0;
         run_done_q   <= 1'b0;
         busy_q       <= 1'b0;
         all_done_q   <= 1'b0;
`ifdef RUN_TIMEOUT_EN
         tmr_q        <= 32'd0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         budget_q     <= budget_d;
         num_runs_q   <= num_runs_d;
         run_idx_q    <= run_idx_d;
         cnt_q        <= cnt_d;
         fcnt_1_q     <= fcnt_1_d;
         fcnt_2_q     <= fcnt_2_d;
         en_1_q       <= en_1_d;
         en_2_q       <= en_2_d;
         ret_1_q      <= ret_1_d;
         ret_2_q      <= ret_2_d;
         core_rst_n_q <= core_rst_n_d;
         run_done_q   <= run_done_d;
         busy_q       <= busy_d;
         all_done_q   <= all_done_d;
`ifdef RUN_TIMEOUT_EN
         tmr_q        <= tmr_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign core_rst_no = core_rst_n_q;
   assign enable_1_o  = en_1_q;
   assign enable_2_o  = en_2_q;
   assign run_idx_o   = run_idx_q;
   assign run_done_o  = run_done_q;
   assign retired_1_o = ret_1_q;
   assign retired_2_o = ret_2_q;
   assign busy_o      = busy_q;
   assign all_done_o  = all_done_q;
`ifdef RUN_TIMEOUT_EN
   assign timeout_o   = timeout_q;
`else
   assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dual_run_sequencer.sv
// Directed/randomized bench for dual_run_sequencer against a count-based run model.
module tb_dual_run_sequencer;

   localparam int CRST = 8;
   localparam int DRN  = 16;
   localparam int TMO  = 20;
`ifdef RUN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] instr_budget_i = 32'd0;
   logic [7:0]  num_runs_i = 8'd0;
   logic        fetch_1_i = 1'b0, fetch_2_i = 1'b0;
   logic        retire_1_i = 1'b0, retire_2_i = 1'b0;
   logic        core_rst_no, enable_1_o, enable_2_o, run_done_o;
   logic        timeout_o, busy_o, all_done_o;
   logic [7:0]  run_idx_o;
   logic [31:0] retired_1_o, retired_2_o;

   int checks = 0;
   int errors = 0;

   // model: budget, accepted fetches, retires, watchdog outcome
   int mB, acc1, acc2, ret1, ret2;
   logic mto;

   dual_run_sequencer #(.CORE_RST_CYCLES(CRST), .DRAIN_CYCLES(DRN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
      .instr_budget_i(instr_budget_i), .num_runs_i(num_runs_i),
      .fetch_1_i(fetch_1_i), .fetch_2_i(fetch_2_i),
      .retire_1_i(retire_1_i), .retire_2_i(retire_2_i),
      .core_rst_no(core_rst_no), .enable_1_o(enable_1_o), .enable_2_o(enable_2_o),
      .run_idx_o(run_idx_o), .run_done_o(run_done_o),
      .retired_1_o(retired_1_o), .retired_2_o(retired_2_o),
      .timeout_o(timeout_o), .busy_o(busy_o), .all_done_o(all_done_o)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic gen(input int per, input int rc);
      if (per > 0) return (rc % per) == 0;
      return 1'($urandom_range(1));
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_core_rst_n"}, core_rst_no, 1'b0);
      chk1({tag, "_en1"}, enable_1_o, 1'b0);
      chk1({tag, "_en2"}, enable_2_o, 1'b0);
      chk32({tag, "_idx"}, {24'd0, run_idx_o}, 32'd0);
      chk32({tag, "_ret1"}, retired_1_o, 32'd0);
      chk32({tag, "_ret2"}, retired_2_o, 32'd0);
      chk1({tag, "_run_done"}, run_done_o, 1'b0);
      chk1({tag, "_timeout"}, timeout_o, 1'b0);
      chk1({tag, "_busy"}, busy_o, 1'b0);
      chk1({tag, "_all_done"}, all_done_o, 1'b0);
   endtask

   task automatic t_core_rst(input int idx);
      acc1 = 0; acc2 = 0; ret1 = 0; ret2 = 0; mto = 1'b0;
      for (int i = 0; i < CRST; i++) begin
         chk1("crst_core_rst_n", core_rst_no, 1'b0);
         chk1("crst_busy", busy_o, 1'b1);
         chk1("crst_en1", enable_1_o, 1'b0);
         chk1("crst_en2", enable_2_o, 1'b0);
         chk32("crst_ret1", retired_1_o, 32'd0);
         chk32("crst_ret2", retired_2_o, 32'd0);
         chk1("crst_timeout", timeout_o, 1'b0);
         chk32("crst_idx", {24'd0, run_idx_o}, 32'(idx));
         // strobes and start here must all be ignored
         fetch_1_i  = 1'($urandom_range(1));
         fetch_2_i  = 1'($urandom_range(1));
         retire_1_i = 1'($urandom_range(1));
         retire_2_i = 1'($urandom_range(1));
         start_i    = 1'($urandom_range(1));
         tick();
      end
      start_i = 1'b0;
   endtask

   task automatic t_run(input int fper1, input int fper2, input int rmode);
      int rc;
      logic e1, e2, f1, f2, r1, r2, ex, to;
      rc = 0;
      forever begin
         e1 = (acc1 < mB);
         e2 = (acc2 < mB);
         chk1("run_core_rst_n", core_rst_no, 1'b1);
         chk1("run_en1", enable_1_o, e1);
         chk1("run_en2", enable_2_o, e2);
         chk32("run_ret1", retired_1_o, 32'(ret1));
         chk32("run_ret2", retired_2_o, 32'(ret2));
         chk1("run_timeout", timeout_o, 1'b0);
         f1 = gen(fper1, rc);
         f2 = gen(fper2, rc);
         r1 = (rmode == 1) ? (f1 && e1) : (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
         r2 = (rmode == 1) ? (f2 && e2) : (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
         ex = (!e1 && !e2) || (ret1 >= mB && ret2 >= mB);
         rc++;
         to = TO_EN && !ex && (rc == TMO);
         if (e1 && f1) acc1++;
         if (e2 && f2) acc2++;
         if (r1) ret1++;
         if (r2) ret2++;
         fetch_1_i = f1; fetch_2_i = f2; retire_1_i = r1; retire_2_i = r2;
         tick();
         if (ex || to) break;
         if (rc > 3000) begin
            checks++;
            errors++;
            $error("FAIL run_bound observed=%0d cycles expected=exit", rc);
            break;
         end
      end
      mto = to;
      if (rmode != 2) begin
         fetch_1_i = 1'b0; fetch_2_i = 1'b0; retire_1_i = 1'b0; retire_2_i = 1'b0;
      end
   endtask

   task automatic t_drain(input int rmode);
      for (int i = 0; i < DRN; i++) begin
         chk1("drain_en1", enable_1_o, 1'b0);
         chk1("drain_en2", enable_2_o, 1'b0);
         chk1("drain_core_rst_n", core_rst_no, 1'b1);
         chk1("drain_run_done", run_done_o, 1'b0);
         chk32("drain_ret1", retired_1_o, 32'(ret1));
         chk32("drain_ret2", retired_2_o, 32'(ret2));
         chk1("drain_timeout", timeout_o, mto);
         fetch_1_i  = 1'($urandom_range(1));
         fetch_2_i  = 1'($urandom_range(1));
         retire_1_i = (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
         retire_2_i = (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
         if (retire_1_i) ret1++;
         if (retire_2_i) ret2++;
         tick();
      end
   endtask

   task automatic t_report(input int idx, input int n);
      chk1("rep_run_done", run_done_o, 1'b1);
      chk1("rep_core_rst_n", core_rst_no, 1'b1);
      chk1("rep_busy", busy_o, 1'b1);
      chk32("rep_idx", {24'd0, run_idx_o}, 32'(idx));
      chk32("rep_ret1", retired_1_o, 32'(ret1));
      chk32("rep_ret2", retired_2_o, 32'(ret2));
      chk1("rep_timeout", timeout_o, mto);
      retire_1_i = 1'b1; retire_2_i = 1'b1;
      tick();
      retire_1_i = 1'b0; retire_2_i = 1'b0;
      fetch_1_i = 1'b0; fetch_2_i = 1'b0;
      if (idx == n - 1) begin
         chk1("done_all_done", all_done_o, 1'b1);
         chk1("done_core_rst_n", core_rst_no, 1'b0);
         chk1("done_busy", busy_o, 1'b0);
         chk1("done_run_done", run_done_o, 1'b0);
         chk32("done_idx", {24'd0, run_idx_o}, 32'(idx));
         chk32("done_ret1", retired_1_o, 32'(ret1));
         chk32("done_ret2", retired_2_o, 32'(ret2));
         chk1("done_timeout", timeout_o, mto);
      end
   endtask

   task automatic start_seq(input int b, input int n);
      mB = b;
      instr_budget_i = 32'(b);
      num_runs_i = 8'(n);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      instr_budget_i = 32'($urandom);
      num_runs_i = 8'($urandom);
   endtask

   task automatic do_seq(input int b, input int n, input int fp1, input int fp2, input int rmode);
      start_seq(b, n);
      if (n == 0) begin
         for (int i = 0; i < 5; i++) begin
            chk1("n0_all_done", all_done_o, 1'b1);
            chk1("n0_core_rst_n", core_rst_no, 1'b0);
            chk1("n0_busy", busy_o, 1'b0);
            tick();
         end
      end else begin
         for (int idx = 0; idx < n; idx++) begin
            t_core_rst(idx);
            t_run(fp1, fp2, rmode);
            t_drain(rmode);
            t_report(idx, n);
         end
      end
   endtask

   initial begin
      mB = 0; acc1 = 0; acc2 = 0; ret1 = 0; ret2 = 0; mto = 1'b0;
      rst_ni = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");
      rst_ni = 1'b1;
      tick();
      chk_reset_vals("idle");

      do_seq(5, 1, 1, 1, 1);     // single run, strobes stop with fetch
      do_seq(3, 1, 1, 4, 1);     // asymmetric fetch rates
      do_seq(2, 3, 0, 0, 2);     // multi-run, random strobes
      do_seq(7, 0, 1, 1, 1);     // N=0
      do_seq(0, 2, 1, 1, 1);     // B=0
      do_seq(100, 1, 2, 2, 0);   // watchdog scenario (normal exit when disabled)
      for (int k = 0; k < 3; k++)
         do_seq(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)), 0, 0, 2);

      // reset in the middle of run 1
      start_seq(4, 3);
      t_core_rst(0);
      t_run(1, 1, 1);
      t_drain(1);
      t_report(0, 3);
      t_core_rst(1);
      for (int i = 0; i < 2; i++) begin
         chk1("mid_en1", enable_1_o, 1'b1);
         tick();
      end
      rst_ni = 1'b0;
      tick();
      chk_reset_vals("midrst");
      rst_ni = 1'b1;
      tick();
      chk_reset_vals("midrst_idle");
      do_seq(2, 1, 1, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_run_sequencer.md
Name: dual_run_sequencer

Overview:
- Sequences back-to-back test runs on the two lockstep core instances in the contract-synthesis verification harness.
- For each run it holds both cores in reset, then gates their fetch with a per-core instruction budget. It waits for completion, lets in-flight retires drain, and reports per-core retire counts.
- Repeats for a programmed number of runs, then asserts all-done to the testbench.

Parameters:
- CORE_RST_CYCLES, 8, cycles core_rst_no is held low at the start of each run (minimum 1).
- DRAIN_CYCLES, 16, cycles spent in DRAIN after fetch stops (minimum 1).
- TIMEOUT_CYCLES, 4096, RUN-state watchdog limit; used only with RUN_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- start_i  in  1  begin a sequence; sampled only in IDLE/DONE.
- instr_budget_i  in  32  fetches allowed per core per run; latched on start.
- num_runs_i  in  8  number of runs; latched on start.
- fetch_1_i, fetch_2_i  in  1  per-core fetch-issued strobes.
- retire_1_i, retire_2_i  in  1  per-core retire strobes.
- core_rst_no  out  1  active-low reset to both cores.
- enable_1_o, enable_2_o  out  1  per-core fetch enables.
- run_idx_o  out  8  index of the current run (0-based).
- run_done_o  out  1  one-cycle pulse when a run's results are valid.
- retired_1_o, retired_2_o  out  32  per-core retire counts for the current/last run.
- timeout_o  out  1  the current/last run ended by watchdog.
- busy_o  out  1  high in CORE_RST, RUN, DRAIN and REPORT.
- all_done_o  out  1  high in DONE.

Behaviour:
- Reset values, applied at the clock edge while rst_ni=0: state=IDLE; core_rst_no=0; enable_1_o, enable_2_o, run_done_o, timeout_o, busy_o and all_done_o all 0; run_idx_o=0; retired_1_o and retired_2_o = 0.
- Reset mid-operation aborts the sequence and returns to these values on the next edge. Nothing is retained.
- The FSM states are IDLE, CORE_RST, RUN, DRAIN, REPORT and DONE. All outputs are registered.
- IDLE/DONE, on start_i=1:
  - Latch budget B and run count N; set run_idx=0.
  - If N=0, go to DONE. Otherwise go to CORE_RST.
  - start_i is ignored in every other state.
- CORE_RST:
  - core_rst_no=0 for exactly CORE_RST_CYCLES cycles.
  - Clear the fetch counters, retired_1_o/retired_2_o and timeout_o on entry.
  - Then go to RUN; core_rst_no=1 and enable_k=1 from the first RUN cycle.
  - If B=0, the enables stay 0 and the first RUN cycle goes straight to DRAIN.
- RUN, fetch gating per core k:
  - A fetch is accepted when enable_k_o=1 and fetch_k_i=1; the fetch count increments.
  - On the accepted fetch that makes the count equal B, enable_k_o drops on the next edge, so exactly B fetches are accepted.
  - fetch_k_i while enable_k_o=0 is ignored. The enables never re-rise within a run.
- Retire counting:
  - retired_k_o increments on retire_k_i in RUN and DRAIN only, and saturates at 32'hFFFF_FFFF.
  - Retire strobes in other states are ignored.
- RUN exits to DRAIN when either condition holds:
  - both enables are 0; or
  - retired_1_o >= B and retired_2_o >= B.
  - When both conditions hold in the same cycle, a single transition occurs.
- On DRAIN entry both enables are forced to 0.
- DRAIN lasts DRAIN_CYCLES cycles, then goes to REPORT.
- REPORT lasts one cycle with run_done_o=1 and core_rst_no=1.
  - If run_idx = N-1, go to DONE; run_idx holds.
  - Otherwise run_idx++ and go to CORE_RST.
- retired_k_o and timeout_o hold their values from REPORT until the next CORE_RST entry.
- In DONE, all_done_o=1 and core_rst_no=0.
- Simultaneous fetch_1_i and fetch_2_i are counted independently. A fetch and a retire on the same core in the same cycle are both counted.

Optional Feature:
- Macro: RUN_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on RUN entry and increments every RUN cycle.
  - When it reaches TIMEOUT_CYCLES while still in RUN, the enables are forced to 0, timeout_o is set (sticky until the next CORE_RST), and the FSM goes to DRAIN.
  - If the normal exit and the timeout occur in the same cycle, the normal exit wins and timeout_o stays 0.
- Undefined: no counter exists, timeout_o is tied to 0, and RUN only exits on the normal conditions.

Test Plan:
- Single run: N=1, B=5, both cores fetch and retire every RUN cycle. Required: exactly 5 accepted fetches per core; enables fall after the 5th. Then run_done_o pulses once with retired_1_o=retired_2_o=5 plus any drain retires (exactly 5 if the strobes stop with fetch). all_done_o=1 one cycle after REPORT.
- Asymmetric cores: B=3, core 1 fetches every cycle, core 2 every 4th cycle. Required: enable_1_o falls about 9 cycles before enable_2_o; DRAIN is entered only after enable_2_o falls.
- Multi-run: N=3, B=2. Required: three run_done_o pulses with run_idx_o=0, 1, 2. core_rst_no is low for 8 cycles before each run. Counters read 0 during each CORE_RST.
- Edge values: N=0 gives all_done_o=1 with core_rst_no never released. B=0 gives enables never asserted, RUN lasting 1 cycle, and retired counts 0.
- Watchdog (RUN_TIMEOUT_EN, TIMEOUT_CYCLES=20): B=100, no retires. Required: enables are forced low after 20 RUN cycles, timeout_o=1 at REPORT, and it is cleared in the next CORE_RST.
- Reset mid-run: rst_ni=0 for 1 cycle during RUN of run 1. Required: all outputs return to reset values on the next edge; start_i then begins again from run_idx_o=0.
